// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared FSM encoding, port indices and defaults for mem_arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } arb_state_t;

    // Port indices, also the encoding of the round-robin last-grant register
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int TIMEOUT_CYC_DEF = 255;
    localparam int WAIT_CNT_W      = 10;

    // Instruction fetches always read a full word
    localparam logic [3:0] FETCH_SEL = 4'hF;

endpackage

// File: rtl/arb_timeout_cnt.sv
// rtl/arb_timeout_cnt.sv - per-access wait counter with expiry compare for mem_arbiter
module arb_timeout_cnt
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic busy,
    output logic expired
);

    localparam logic [WAIT_CNT_W-1:0] LAST_CNT = WAIT_CNT_W'(TIMEOUT_CYC - 1);

    logic [WAIT_CNT_W-1:0] cnt;

    // Held at zero while idle so the first busy cycle always sees 0; stops at the last count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!busy) begin
            cnt <= '0;
        end else if (cnt != LAST_CNT) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = busy && (cnt == LAST_CNT);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) single-RAM arbiter with timeout; ARB_RR_EN selects round-robin
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_ready_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_data_i,
    input  logic [3:0]  d_sel_i,
    output logic [31:0] d_data_o,
    output logic        d_ready_o,
    output logic        ram_ce_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_data_o,
    output logic [3:0]  ram_sel_o,
    input  logic [31:0] ram_data_i,
    input  logic        ram_data_ready,
    output logic        err_o
);

    arb_state_t  state;
    arb_state_t  state_nxt;

    logic [31:0] lat_addr;
    logic [31:0] lat_data;
    logic        lat_we;
    logic [3:0]  lat_sel;

    logic        if_ready_q;
    logic        d_ready_q;
    logic        err_q;
    logic [31:0] if_data_q;
    logic [31:0] d_data_q;

    logic        req_i;
    logic        req_d;
    logic        pick_d;
    logic        grant;
    logic        busy;
    logic        expired;
    logic        done;

    // A requester still holds req during its own ready cycle; ignore it there so it is not re-served
    assign req_i = if_req_i & ~if_ready_q;
    assign req_d = d_req_i  & ~d_ready_q;

`ifdef ARB_RR_EN
    logic last_grant;

    // Remember which port won the most recent grant; reset as if fetch went last
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= PORT_I;
        end else if (grant) begin
            last_grant <= pick_d ? PORT_D : PORT_I;
        end
    end

    assign pick_d = req_d & (~req_i | (last_grant == PORT_I));
`else
    assign pick_d = req_d;
`endif

    assign busy  = (state != ST_IDLE);
    assign grant = (state == ST_IDLE) && (req_i || req_d);
    assign done  = busy && (ram_data_ready || expired);

    arb_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .busy    (busy),
        .expired (expired)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: grant from idle, return to idle on RAM completion or timeout
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (grant) begin
                    state_nxt = pick_d ? ST_BUSY_D : ST_BUSY_I;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // RAM outputs come only from the latched access while busy, all zero when idle
    always_comb begin
        ram_ce_o   = 1'b0;
        ram_we_o   = 1'b0;
        ram_addr_o = '0;
        ram_data_o = '0;
        ram_sel_o  = '0;
        if (busy) begin
            ram_ce_o   = 1'b1;
            ram_we_o   = lat_we;
            ram_addr_o = lat_addr;
            ram_data_o = lat_data;
            ram_sel_o  = lat_sel;
        end
    end

    // Capture the winner's request at grant time so later input changes cannot disturb the access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_addr <= '0;
            lat_data <= '0;
            lat_we   <= 1'b0;
            lat_sel  <= '0;
        end else if (grant) begin
            lat_addr <= pick_d ? d_addr_i : if_addr_i;
            lat_data <= pick_d ? d_data_i : '0;
            lat_we   <= pick_d & d_we_i;
            lat_sel  <= pick_d ? d_sel_i : FETCH_SEL;
        end
    end

    // Completion pulses; read data only on a real RAM read, zero for writes and timeouts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            err_q      <= 1'b0;
            if_data_q  <= '0;
            d_data_q   <= '0;
        end else begin
            if_ready_q <= (state == ST_BUSY_I) && done;
            d_ready_q  <= (state == ST_BUSY_D) && done;
            err_q      <= done && !ram_data_ready;
            if_data_q  <= ((state == ST_BUSY_I) && ram_data_ready) ? ram_data_i : '0;
            d_data_q   <= ((state == ST_BUSY_D) && ram_data_ready && !lat_we) ? ram_data_i : '0;
        end
    end

    assign if_ready_o = if_ready_q;
    assign d_ready_o  = d_ready_q;
    assign err_o      = err_q;
    assign if_data_o  = if_data_q;
    assign d_data_o   = d_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_data = '0;
    logic [3:0]  d_sel = '0;
    logic [31:0] ram_rdata = '0;
    logic        ram_rdy = 1'b0;

    logic [31:0] if_data_o, d_data_o, ram_addr_o, ram_data_o;
    logic        if_ready_o, d_ready_o, ram_ce_o, ram_we_o, err_o;
    logic [3:0]  ram_sel_o;

    int total = 0;
    int bad = 0;
    int last_served = 0;

    // Model view of each port's request: index 0 = fetch, 1 = data
    logic [31:0] m_addr[2];
    logic [31:0] m_wdata[2];
    logic [31:0] m_rdata[2];
    logic        m_we[2];
    logic [3:0]  m_sel[2];
    int          m_dly[2];

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data_o), .if_ready_o(if_ready_o),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_data_i(d_data), .d_sel_i(d_sel),
        .d_data_o(d_data_o), .d_ready_o(d_ready_o),
        .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
        .ram_sel_o(ram_sel_o), .ram_data_i(ram_rdata), .ram_data_ready(ram_rdy), .err_o(err_o)
    );

    task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [69:0] ram_vec();
        return {ram_ce_o, ram_we_o, ram_sel_o, ram_addr_o, ram_data_o};
    endfunction

    function automatic logic [69:0] rdy_vec();
        return {67'd0, if_ready_o, d_ready_o, err_o};
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_ram"}, ram_vec(), '0);
        chk({tag, "_rdy"}, rdy_vec(), '0);
    endtask

    task automatic setup(input int p, input logic [31:0] addr, input logic we, input logic [3:0] sel,
                         input logic [31:0] wdata, input int dly, input logic [31:0] rdata);
        m_addr[p]  = addr;
        m_we[p]    = (p == 1) ? we : 1'b0;
        m_sel[p]   = (p == 1) ? sel : 4'hF;
        m_wdata[p] = (p == 1) ? wdata : 32'h0;
        m_dly[p]   = dly;
        m_rdata[p] = rdata;
    endtask

    task automatic setup_rand(input int p);
        setup(p, $urandom, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom_range(0, 5), $urandom);
    endtask

    task automatic drive_port(input int p);
        if (p == 0) begin
            if_addr = m_addr[0];
        end else begin
            d_addr = m_addr[1];
            d_we   = m_we[1];
            d_sel  = m_sel[1];
            d_data = m_wdata[1];
        end
    endtask

    task automatic set_req(input int p, input logic v);
        if (p == 0) if_req = v;
        else d_req = v;
    endtask

    task automatic wobble_port(input int p);
        if (p == 0) begin
            if_addr = $urandom;
        end else begin
            d_addr = $urandom;
            d_data = $urandom;
            d_sel  = 4'($urandom);
            d_we   = 1'($urandom_range(0, 1));
        end
    endtask

    // One arbitration round: model decides service order, busy length and completion values
    task automatic scenario(input bit ri, input bit rd, input bit wobble, input bit drop);
        int order[$];
        int p;
        int len;
        int prev;
        bit timed_out;
        logic [31:0] exp_data;

        @(posedge clk); #1;
        if_req = ri;
        d_req  = rd;
        drive_port(0);
        drive_port(1);
        ram_rdy   = 1'($urandom_range(0, 1));
        ram_rdata = $urandom;
        #1 check_idle("grant");

        if (ri && rd) begin
`ifdef ARB_RR_EN
            if (last_served == 1) order = '{0, 1};
            else order = '{1, 0};
`else
            order = '{1, 0};
`endif
        end else if (rd) begin
            order = '{1};
        end else begin
            order = '{0};
        end

        prev = -1;
        foreach (order[k]) begin
            p = order[k];
            timed_out = (m_dly[p] >= T);
            len = timed_out ? T : m_dly[p] + 1;
            for (int b = 0; b < len; b++) begin
                @(posedge clk); #1;
                if (prev >= 0) begin
                    set_req(prev, 1'b0);
                    prev = -1;
                end
                ram_rdy   = (b == m_dly[p]);
                ram_rdata = (b == m_dly[p]) ? m_rdata[p] : $urandom;
                if (wobble) wobble_port(p);
                if (drop && b == 0) set_req(p, 1'b0);
                #1;
                chk("busy_ram", ram_vec(), {1'b1, m_we[p], m_sel[p], m_addr[p], m_wdata[p]});
                chk("busy_rdy", rdy_vec(), '0);
            end
            @(posedge clk); #1;
            ram_rdy   = 1'($urandom_range(0, 1));
            ram_rdata = $urandom;
            #1;
            exp_data = (timed_out || m_we[p]) ? 32'h0 : m_rdata[p];
            chk("done_ram", ram_vec(), '0);
            chk("done_rdy", rdy_vec(), {67'd0, p == 0, p == 1, timed_out});
            if (p == 0) chk("if_data", {38'd0, if_data_o}, {38'd0, exp_data});
            else chk("d_data", {38'd0, d_data_o}, {38'd0, exp_data});
            prev = p;
            last_served = p;
        end

        @(posedge clk); #1;
        if_req  = 1'b0;
        d_req   = 1'b0;
        ram_rdy = 1'($urandom_range(0, 1));
        #1 check_idle("tail");
    endtask

    initial begin
        bit ri;
        bit rd;

        // Reset state
        repeat (2) @(posedge clk);
        #1 check_idle("reset");
        chk("reset_data", {6'd0, if_data_o, d_data_o}, '0);
        @(negedge clk);
        rst = 1'b1;

        // Fetch, RAM answers on third busy cycle with 0x13
        setup(0, 32'h0000_0040, 1'b0, 4'h0, 32'h0, 2, 32'h0000_0013);
        scenario(1, 0, 0, 0);

        // Data write
        setup(1, 32'h0000_0100, 1'b1, 4'b0011, 32'hDEAD_BEEF, 1, 32'hFFFF_FFFF);
        scenario(0, 1, 0, 0);

        // Simultaneous requests; data served last so round-robin builds serve fetch first
        setup(0, 32'h0000_2000, 1'b0, 4'h0, 32'h0, 0, 32'h1111_2222);
        setup(1, 32'h0000_3000, 1'b0, 4'hF, 32'h5555_AAAA, 0, 32'h3333_4444);
        scenario(1, 1, 0, 0);

        // Timeout: RAM never ready
        setup(1, 32'h0000_0200, 1'b0, 4'hF, 32'h0, 99, 32'h0);
        scenario(0, 1, 0, 0);

        // Ready exactly on the last allowed cycle: ready wins
        setup(1, 32'h0000_0300, 1'b0, 4'hC, 32'h0, T - 1, 32'hCAFE_F00D);
        scenario(0, 1, 0, 0);

        // Address changes mid-access, and requester dropping mid-access
        setup(0, 32'h0000_0400, 1'b0, 4'h0, 32'h0, 3, 32'h0BAD_C0DE);
        scenario(1, 0, 1, 0);
        setup(1, 32'h0000_0500, 1'b0, 4'hF, 32'h0, 2, 32'h1234_5678);
        scenario(0, 1, 0, 1);

        // Randomized rounds
        for (int i = 0; i < 60; i++) begin
            ri = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            if (!ri && !rd) ri = 1'b1;
            setup_rand(0);
            setup_rand(1);
            scenario(ri, rd, 1'($urandom_range(0, 1)), (!(ri && rd)) && ($urandom_range(0, 3) == 0));
        end

        // Reset in the middle of a data access
        setup(1, 32'h0000_0600, 1'b0, 4'hF, 32'h0, 99, 32'h0);
        @(posedge clk); #1;
        d_req = 1'b1;
        drive_port(1);
        ram_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("pre_rst_ce", {69'd0, ram_ce_o}, 70'd1);
        #2 rst = 1'b0;
        #1;
        check_idle("async_rst");
        chk("async_rst_data", {6'd0, if_data_o, d_data_o}, '0);
        d_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        last_served = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            ram_rdy = 1'($urandom_range(0, 1));
            #1 check_idle("post_rst");
        end

        // Arbitration after reset behaves as from power-up
        setup_rand(0);
        setup_rand(1);
        scenario(1, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
